// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory loader.
// The stream is: count lo, count hi, count*4 data bytes (LE words), XOR checksum.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int            BYTES_PER_WORD = 4;
  localparam logic [15:0]   LEN_MIN        = 16'd1;
  localparam logic [7:0]    CHK_INIT       = 8'h00;

  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  function automatic logic is_loading(input state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

  function automatic logic is_idle_like(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four bytes little-endian; word is valid combinationally with the 4th byte.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [23:0] shift_r;
  logic [1:0]  idx_r;

  assign word          = {byte_in, shift_r};
  assign word_complete = shift_en && (idx_r == 2'(BYTES_PER_WORD - 1));

  // Byte shift register and byte index within the current word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r <= 24'h000000;
      idx_r   <= 2'd0;
    end else if (clear) begin
      shift_r <= 24'h000000;
      idx_r   <= 2'd0;
    end else if (shift_en) begin
      shift_r <= {byte_in, shift_r[23:8]};
      idx_r   <= idx_r + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Frames a host byte stream into IMem word writes and holds the core in reset
// until a load finishes with a matching checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 7,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we0,
  output logic [31:0]       wr_din0,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_t            state_r, state_n;
  logic [15:0]       count_r;
  logic [15:0]       word_cnt_r;
  logic [ADDR_W-1:0] addr_r;
  logic [7:0]        chk_r;

  logic              xfer_s;
  logic              start_acc_s;
  logic              shift_en_s;
  logic              word_complete_s;
  logic [31:0]       word_s;
  logic [15:0]       len_full_s;
  logic              len_bad_s;
  logic              last_word_s;

  assign xfer_s      = byte_valid && byte_ready;
  assign start_acc_s = start && is_idle_like(state_r);
  assign shift_en_s  = xfer_s && (state_r == ST_DATA);
  assign len_full_s  = {byte_data, count_r[7:0]};
  assign len_bad_s   = (len_full_s < LEN_MIN) || (len_full_s > 16'(MAX_WORDS));
  assign last_word_s = (word_cnt_r + 16'd1) == count_r;

  word_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_acc_s),
    .shift_en      (shift_en_s),
    .byte_in       (byte_data),
    .word          (word_s),
    .word_complete (word_complete_s)
  );

  // Next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_n = ST_LEN_LO;
        else       state_n = state_r;
      end
      ST_LEN_LO: begin
        if (xfer_s) state_n = ST_LEN_HI;
        else        state_n = state_r;
      end
      ST_LEN_HI: begin
        if (xfer_s && len_bad_s)  state_n = ST_ERR;
        else if (xfer_s)          state_n = ST_DATA;
        else                      state_n = state_r;
      end
      ST_DATA: begin
        if (word_complete_s && last_word_s) state_n = ST_CHECK;
        else                                state_n = state_r;
      end
      ST_CHECK: begin
        if (xfer_s && (byte_data == chk_r)) state_n = ST_DONE;
        else if (xfer_s)                    state_n = ST_ERR;
        else                                state_n = state_r;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register, counters, checksum and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      count_r    <= 16'd0;
      word_cnt_r <= 16'd0;
      addr_r     <= '0;
      chk_r      <= CHK_INIT;
      byte_ready <= 1'b0;
      we0        <= 1'b0;
      wr_din0    <= 32'h0000_0000;
      wr_addr0   <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_r    <= state_n;
      byte_ready <= is_loading(state_n);
      we0        <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            count_r    <= 16'd0;
            word_cnt_r <= 16'd0;
            addr_r     <= '0;
            chk_r      <= CHK_INIT;
            cpu_reset  <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
          end
        end
        ST_LEN_LO: begin
          if (xfer_s) count_r[7:0] <= byte_data;
        end
        ST_LEN_HI: begin
          if (xfer_s) begin
            count_r[15:8] <= byte_data;
            if (len_bad_s) begin
              error <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            chk_r <= chk_update(chk_r, byte_data);
            // The limit on count keeps addr_r from wrapping within a load
            if (word_complete_s) begin
              we0        <= 1'b1;
              wr_din0    <= word_s;
              wr_addr0   <= addr_r;
              addr_r     <= addr_r + ADDR_W'(1);
              word_cnt_r <= word_cnt_r + 16'd1;
            end
          end
        end
        ST_CHECK: begin
          if (xfer_s) begin
            busy <= 1'b0;
            if (byte_data == chk_r) begin
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: begin
          we0 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader: each record is a host byte
// stream plus the expected writes and final status flags.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        we0;
  logic [31:0] wr_din0;
  logic [6:0]  wr_addr0;
  logic        cpu_reset, busy, done, error;

  imem_loader #(.ADDR_W(7), .MAX_WORDS(128)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .we0(we0), .wr_din0(wr_din0), .wr_addr0(wr_addr0),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] stream;   // first byte in [127:120]
    int           nbytes;
    bit           gaps;
    bit           poke;     // pulse start mid-load
    bit           exp_done;
    bit           exp_err;
    int           nwr;
    logic [95:0]  words;    // word k in [32*k +: 32]
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] cap_data [16];
  logic [6:0]  cap_addr [16];
  int          cap_n = 0;

  // Write capture, sampled mid-cycle
  always @(negedge clk) begin
    if (we0 && cap_n < 16) begin
      cap_data[cap_n] <= wr_din0;
      cap_addr[cap_n] <= wr_addr0;
      cap_n           <= cap_n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!byte_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL handshake_timeout: got byte_ready=0 expected 1");
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_data  = 8'h5a;
  endtask

  task automatic run_vector(input vec_t v);
    int base;
    base  = cap_n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < v.nbytes; i++) begin
      if (v.poke && i == 3) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      send_byte(v.stream[127 - 8*i -: 8], v.gaps ? int'($urandom_range(0, 5)) : 0);
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk({v.name, "_done"},       32'(done),       32'(v.exp_done));
    chk({v.name, "_error"},      32'(error),      32'(v.exp_err));
    chk({v.name, "_cpu_reset"},  32'(cpu_reset),  32'(!v.exp_done));
    chk({v.name, "_busy"},       32'(busy),       32'h0);
    chk({v.name, "_byte_ready"}, 32'(byte_ready), 32'h0);
    chk({v.name, "_nwrites"},    32'(cap_n - base), 32'(v.nwr));
    for (int k = 0; k < v.nwr; k++) begin
      if (base + k < 16) begin
        chk({v.name, "_addr"}, 32'(cap_addr[base + k]), 32'(k));
        chk({v.name, "_data"}, cap_data[base + k], v.words[32*k +: 32]);
      end
    end
  endtask

  vec_t vecs [7];

  // Overall time bound
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"single", {8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h83, 72'h0},
                7, 1'b0, 1'b0, 1'b1, 1'b0, 1, {64'h0, 32'h0010_0093}};
    vecs[1] = '{"three", {8'h03, 8'h00, {4{8'h11}}, {4{8'h22}}, {4{8'h33}}, 8'h00, 8'h00},
                15, 1'b0, 1'b0, 1'b1, 1'b0, 3, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
    vecs[2] = '{"badchk", {8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h84, 72'h0},
                7, 1'b0, 1'b0, 1'b0, 1'b1, 1, {64'h0, 32'h0010_0093}};
    vecs[3] = '{"len0", {8'h00, 8'h00, 112'h0},
                2, 1'b0, 1'b0, 1'b0, 1'b1, 0, 96'h0};
    vecs[4] = '{"len129", {8'h81, 8'h00, 112'h0},
                2, 1'b0, 1'b0, 1'b0, 1'b1, 0, 96'h0};
    vecs[5] = '{"single_gaps", {8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h83, 72'h0},
                7, 1'b1, 1'b1, 1'b1, 1'b0, 1, {64'h0, 32'h0010_0093}};
    vecs[6] = '{"three_gaps", {8'h03, 8'h00, {4{8'h11}}, {4{8'h22}}, {4{8'h33}}, 8'h00, 8'h00},
                15, 1'b1, 1'b1, 1'b1, 1'b0, 3, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we0",        32'(we0),        32'h0);
    chk("rst_wr_din0",    wr_din0,         32'h0);
    chk("rst_wr_addr0",   32'(wr_addr0),   32'h0);
    chk("rst_byte_ready", 32'(byte_ready), 32'h0);
    chk("rst_busy",       32'(busy),       32'h0);
    chk("rst_done",       32'(done),       32'h0);
    chk("rst_error",      32'(error),      32'h0);
    chk("rst_cpu_reset",  32'(cpu_reset),  32'h1);
    reset = 1'b0;
    @(posedge clk); #1;

    // byte_valid in IDLE must not start anything
    byte_valid = 1'b1;
    byte_data  = 8'h01;
    repeat (3) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    chk("idle_valid_busy",       32'(busy),       32'h0);
    chk("idle_valid_byte_ready", 32'(byte_ready), 32'h0);

    for (int i = 0; i < 7; i++) run_vector(vecs[i]);

    // Reset after two data bytes
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h93, 0);
    send_byte(8'h00, 0);
    chk("midrst_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst_we0",        32'(we0),        32'h0);
    chk("midrst_wr_din0",    wr_din0,         32'h0);
    chk("midrst_wr_addr0",   32'(wr_addr0),   32'h0);
    chk("midrst_byte_ready", 32'(byte_ready), 32'h0);
    chk("midrst_busy",       32'(busy),       32'h0);
    chk("midrst_done",       32'(done),       32'h0);
    chk("midrst_error",      32'(error),      32'h0);
    chk("midrst_cpu_reset",  32'(cpu_reset),  32'h1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_vector(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
